mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Sole owner of the byte-wide RAM port. Arbitrates three requesters: ROB store commit,
//  load buffer, and instruction fetch. Serialises each 1/2/4-byte access into per-byte RAM
//  cycles and returns completion pulses. Loads are sign/zero-extended; fetch is always 4 bytes.
// PARAMETERS
//  ADDR_W   32        address width
//  DATA_W   32        word width
//  IO_BASE  32'h30000 first I/O-mapped address; stores here obey io_buffer_full_in
// PORTS
//  clk_in            in   1      clock
//  rst_in            in   1      synchronous, active-high reset
//  rdy_in            in   1      global enable; low = freeze all state and outputs
//  flush_in          in   1      mispredict flush: abort fetch/load, never a store
//  rob_en_in         in   1      store request (level, ROB head)
//  rob_addr_in       in   32     store address
//  rob_wdata_in      in   32     store data, LSB-first
//  rob_type_in       in   INST_TYPE  SB/SH/SW
//  rob_rdy_out       out  1      controller IDLE, new request acceptable
//  rob_finish_out    out  1      1-cycle pulse: store fully written
//  lb_en_in          in   1      load request
//  lb_addr_in        in   32     load address
//  lb_type_in        in   INST_TYPE  LB/LH/LW/LBU/LHU
//  lb_finish_out     out  1      1-cycle pulse: lb_data_out valid
//  lb_data_out       out  32     extended load result
//  if_en_in          in   1      fetch request
//  if_addr_in        in   32     fetch PC
//  if_finish_out     out  1      1-cycle pulse: if_inst_out valid
//  if_inst_out       out  32     fetched instruction
//  io_buffer_full_in in   1      UART buffer full
//  mem_din           in   8      RAM read byte (valid cycle after mem_a)
//  mem_dout          out  8      RAM write byte
//  mem_a             out  32     RAM byte address
//  mem_wr            out  1      1 = write
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all *_finish_out=0, mem_wr=0, mem_a=0, mem_dout=0,
//   data outs=0, rob_rdy_out=1.
//  States IDLE, READ, WRITE. cnt = byte index; len = 1/2/4 from type (fetch = 4).
//  IDLE, edge t, priority: rob_en_in > lb_en_in > if_en_in. Latch owner/addr/type/data,
//   drive mem_a=addr, byte 0 (WRITE: mem_wr=1, mem_dout=wdata[7:0]); go READ/WRITE.
//  READ: edge t+k (1<=k<len) drives mem_a=addr+k; byte k-1 captured from mem_din into
//   buf[8k-1:8k-8]. Edge t+len captures last byte, pulses owner's finish with extended
//   data (LB/LH sign, LBU/LHU zero), returns IDLE.
//  WRITE: edge t+k (k<len) drives mem_a=addr+k, mem_dout=byte k. Edge t+len: mem_wr=0,
//   rob_finish_out=1, IDLE.
//  Latency: accept at edge t, finish visible after edge t+len; earliest next accept t+len+1.
//  rob_rdy_out = (state==IDLE) combinational; requesters hold en until their finish.
//  Store to addr>=IO_BASE with io_buffer_full_in=1: not accepted, IDLE held, lower
//   priorities still blocked that cycle (no reordering past a committed store).
//  flush_in: READ -> IDLE same edge, no finish pulse, buf discarded. IDLE: fetch/load
//   requests ignored that edge; a store request is still accepted. WRITE: ignored.
//  rdy_in=0: every register holds (incl. mem_wr, cnt, finish pulses not repeated/dropped
//   -> pulse widths counted in rdy_in=1 cycles only).
//  Address arithmetic wraps mod 2^32. rst_in mid-access: immediate IDLE, mem_wr=0.
//  All finish outputs are mutually exclusive; at most one per cycle.
// STRUCTURE
//  define.vh: inst type codes (LB..LHU, SB..SW), ENABLE/DISABLE, ADDRESS_WIDTH,
//   INSTRUCTION_WIDTH. Local: state encoding, owner encoding (ROB/LB/IF).
//  Single module; extension/len decode as functions. No sub-module.
// TESTING
//  Fetch 0x100, RAM bytes 13 05 00 00 -> if_finish after 4 edges, if_inst_out=0x00000513.
//  LB from byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0xFF7F -> 0xFFFFFF7F.
//  SW 0xDEADBEEF @0x200 -> mem_wr 4 cycles, bytes EF BE AD DE at 0x200..0x203, one finish.
//  Store+load+fetch asserted same cycle -> store served first, then load, then fetch.
//  Load in flight, flush_in at byte 2 -> IDLE next edge, no lb_finish; store mid-flush completes.
//  SB to 0x30000 with io_buffer_full_in=1 for 5 cycles -> no mem_wr until it drops.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: instruction access types and
// the datapath widths the rest of the core assumes.
package mem_ctrl_pkg;

  typedef logic [3:0] inst_type_t;

  localparam inst_type_t LB  = 4'd0;
  localparam inst_type_t LH  = 4'd1;
  localparam inst_type_t LW  = 4'd2;
  localparam inst_type_t LBU = 4'd3;
  localparam inst_type_t LHU = 4'd4;
  localparam inst_type_t SB  = 4'd5;
  localparam inst_type_t SH  = 4'd6;
  localparam inst_type_t SW  = 4'd7;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int ADDRESS_WIDTH     = 32;
  localparam int INSTRUCTION_WIDTH = 32;

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port owner: arbitrates store commit, load buffer and fetch,
// serialising each access into one RAM cycle per byte.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              rob_en_in,
  input  logic [ADDR_W-1:0] rob_addr_in,
  input  logic [DATA_W-1:0] rob_wdata_in,
  input  inst_type_t        rob_type_in,
  output logic              rob_rdy_out,
  output logic              rob_finish_out,
  input  logic              lb_en_in,
  input  logic [ADDR_W-1:0] lb_addr_in,
  input  inst_type_t        lb_type_in,
  output logic              lb_finish_out,
  output logic [DATA_W-1:0] lb_data_out,
  input  logic              if_en_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_finish_out,
  output logic [DATA_W-1:0] if_inst_out,
  input  logic              io_buffer_full_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [1:0] OWN_ROB = 2'd0;
  localparam logic [1:0] OWN_LB  = 2'd1;
  localparam logic [1:0] OWN_IF  = 2'd2;

  function automatic logic [2:0] access_len(input inst_type_t t);
    case (t)
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input inst_type_t t,
                                                    input logic [DATA_W-1:0] w);
    case (t)
      LB:      return {{(DATA_W-8){w[7]}}, w[7:0]};
      LBU:     return {{(DATA_W-8){1'b0}}, w[7:0]};
      LH:      return {{(DATA_W-16){w[15]}}, w[15:0]};
      LHU:     return {{(DATA_W-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  logic [1:0]        state_q;
  logic [2:0]        cnt_q;
  logic [1:0]        owner_q;
  logic [ADDR_W-1:0] addr_q;
  inst_type_t        type_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;

  logic [DATA_W-1:0] rbuf_merged;
  logic [7:0]        wbyte;
  logic [2:0]        len;
  logic [ADDR_W-1:0] addr_next;
  logic              store_blocked;

  assign len           = access_len(type_q);
  assign addr_next     = addr_q + ADDR_W'(cnt_q);
  assign store_blocked = (rob_addr_in >= IO_BASE) && io_buffer_full_in;
  assign rob_rdy_out   = (state_q == ST_IDLE);

  // The byte arriving on mem_din belongs to the address driven one cycle earlier.
  always_comb begin
    rbuf_merged = rbuf_q;
    case (cnt_q)
      3'd1:    rbuf_merged[7:0]   = mem_din;
      3'd2:    rbuf_merged[15:8]  = mem_din;
      3'd3:    rbuf_merged[23:16] = mem_din;
      3'd4:    rbuf_merged[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    case (cnt_q)
      3'd1:    wbyte = wdata_q[15:8];
      3'd2:    wbyte = wdata_q[23:16];
      3'd3:    wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      owner_q        <= OWN_ROB;
      addr_q         <= '0;
      type_q         <= LB;
      wdata_q        <= '0;
      rbuf_q         <= '0;
      rob_finish_out <= 1'b0;
      lb_finish_out  <= 1'b0;
      if_finish_out  <= 1'b0;
      lb_data_out    <= '0;
      if_inst_out    <= '0;
      mem_dout       <= 8'h00;
      mem_a          <= '0;
      mem_wr         <= 1'b0;
    end else if (rdy_in) begin
      rob_finish_out <= 1'b0;
      lb_finish_out  <= 1'b0;
      if_finish_out  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A pending store holds off loads and fetches even while it waits on the UART.
          if (rob_en_in) begin
            if (!store_blocked) begin
              owner_q  <= OWN_ROB;
              addr_q   <= rob_addr_in;
              type_q   <= rob_type_in;
              wdata_q  <= rob_wdata_in;
              mem_a    <= rob_addr_in;
              mem_dout <= rob_wdata_in[7:0];
              mem_wr   <= 1'b1;
              cnt_q    <= 3'd1;
              state_q  <= ST_WRITE;
            end
          end else if (!flush_in && lb_en_in) begin
            owner_q <= OWN_LB;
            addr_q  <= lb_addr_in;
            type_q  <= lb_type_in;
            rbuf_q  <= '0;
            mem_a   <= lb_addr_in;
            mem_wr  <= 1'b0;
            cnt_q   <= 3'd1;
            state_q <= ST_READ;
          end else if (!flush_in && if_en_in) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr_in;
            type_q  <= LW;
            rbuf_q  <= '0;
            mem_a   <= if_addr_in;
            mem_wr  <= 1'b0;
            cnt_q   <= 3'd1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (flush_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end else if (cnt_q < len) begin
            rbuf_q <= rbuf_merged;
            mem_a  <= addr_next;
            cnt_q  <= cnt_q + 3'd1;
          end else begin
            rbuf_q  <= rbuf_merged;
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            if (owner_q == OWN_LB) begin
              lb_finish_out <= 1'b1;
              lb_data_out   <= extend_load(type_q, rbuf_merged);
            end else begin
              if_finish_out <= 1'b1;
              if_inst_out   <= rbuf_merged;
            end
          end
        end
        ST_WRITE: begin
          if (cnt_q < len) begin
            mem_a    <= addr_next;
            mem_dout <= wbyte;
            cnt_q    <= cnt_q + 3'd1;
          end else begin
            mem_wr         <= 1'b0;
            rob_finish_out <= 1'b1;
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mem_wr  <= 1'b0;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requesters push expected completions, a
// monitor pops and compares them whenever a finish pulse appears.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int K_ROB = 0;
  localparam int K_LB  = 1;
  localparam int K_IF  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        rob_en_in, lb_en_in, if_en_in, io_buffer_full_in;
  logic [31:0] rob_addr_in, rob_wdata_in, lb_addr_in, if_addr_in;
  inst_type_t  rob_type_in, lb_type_in;
  logic        rob_rdy_out, rob_finish_out, lb_finish_out, if_finish_out;
  logic [31:0] lb_data_out, if_inst_out, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr;

  logic [7:0]  ram [0:1023];

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   chk_cnt   = 0;
  int   wr_cycles = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .IO_BASE(32'h30000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rob_en_in(rob_en_in), .rob_addr_in(rob_addr_in), .rob_wdata_in(rob_wdata_in),
    .rob_type_in(rob_type_in), .rob_rdy_out(rob_rdy_out), .rob_finish_out(rob_finish_out),
    .lb_en_in(lb_en_in), .lb_addr_in(lb_addr_in), .lb_type_in(lb_type_in),
    .lb_finish_out(lb_finish_out), .lb_data_out(lb_data_out),
    .if_en_in(if_en_in), .if_addr_in(if_addr_in), .if_finish_out(if_finish_out),
    .if_inst_out(if_inst_out), .io_buffer_full_in(io_buffer_full_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM model: combinational read of the currently addressed byte, image loaded during reset.
  assign mem_din = ram[mem_a[9:0]];

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h00;
      ram[10'h104] <= 8'h93; ram[10'h105] <= 8'h00; ram[10'h106] <= 8'h10; ram[10'h107] <= 8'h00;
      ram[10'h080] <= 8'h80;
      ram[10'h090] <= 8'h7F; ram[10'h091] <= 8'hFF;
    end else if (rdy_in && mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic push_exp(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = 2'(kind);
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic fin_of(input int kind);
    case (kind)
      K_ROB:   return rob_finish_out;
      K_LB:    return lb_finish_out;
      default: return if_finish_out;
    endcase
  endfunction

  // Holds the request level until the matching finish; returns edges taken.
  task automatic run_req(input int kind, input logic [31:0] a, input inst_type_t ty,
                         input logic [31:0] d, output int n);
    n = 0;
    case (kind)
      K_ROB: begin rob_addr_in = a; rob_type_in = ty; rob_wdata_in = d; rob_en_in = 1'b1; end
      K_LB:  begin lb_addr_in = a; lb_type_in = ty; lb_en_in = 1'b1; end
      default: begin if_addr_in = a; if_en_in = 1'b1; end
    endcase
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (!fin_of(kind) && n < 200);
    check($sformatf("req_done_k%0d", kind), 32'(fin_of(kind)), 32'd1);
    case (kind)
      K_ROB:   rob_en_in = 1'b0;
      K_LB:    lb_en_in  = 1'b0;
      default: if_en_in  = 1'b0;
    endcase
  endtask

  always @(negedge clk_in) begin
    int   nfin;
    int   kind;
    exp_t e;
    if (!rst_in && rdy_in) begin
      if (mem_wr) wr_cycles++;
      nfin = int'(rob_finish_out) + int'(lb_finish_out) + int'(if_finish_out);
      if (nfin > 1) begin
        check("finish_exclusive", 32'(nfin), 32'd1);
      end else if (nfin == 1) begin
        kind = rob_finish_out ? K_ROB : (lb_finish_out ? K_LB : K_IF);
        if (exp_q.size() == 0) begin
          check("unexpected_finish", 32'(kind), 32'd3);
        end else begin
          e = exp_q.pop_front();
          check("finish_owner", 32'(kind), 32'(e.kind));
          if (kind == K_LB) check("lb_data", lb_data_out, e.data);
          else if (kind == K_IF) check("if_inst", if_inst_out, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, n2, wr_base;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full_in = 1'b0;
    rob_en_in = 1'b0; lb_en_in = 1'b0; if_en_in = 1'b0;
    rob_addr_in = '0; rob_wdata_in = '0; lb_addr_in = '0; if_addr_in = '0;
    rob_type_in = SB; lb_type_in = LB;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_rob_rdy", 32'(rob_rdy_out), 32'd1);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_finish", {29'd0, rob_finish_out, lb_finish_out, if_finish_out}, 32'd0);
    check("rst_lb_data", lb_data_out, 32'd0);
    check("rst_if_inst", if_inst_out, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Fetch: accept edge + 4 byte edges.
    push_exp(K_IF, 32'h0000_0513);
    run_req(K_IF, 32'h100, LW, 32'd0, n0);
    check("fetch_latency", 32'(n0), 32'd5);

    push_exp(K_LB, 32'hFFFF_FF80); run_req(K_LB, 32'h80, LB,  32'd0, n0);
    check("lb_latency", 32'(n0), 32'd2);
    push_exp(K_LB, 32'h0000_0080); run_req(K_LB, 32'h80, LBU, 32'd0, n0);
    push_exp(K_LB, 32'hFFFF_FF7F); run_req(K_LB, 32'h90, LH,  32'd0, n0);
    push_exp(K_LB, 32'h0000_FF7F); run_req(K_LB, 32'h90, LHU, 32'd0, n0);
    push_exp(K_LB, 32'h0000_0513); run_req(K_LB, 32'h100, LW, 32'd0, n0);

    // Word store: four write cycles, one finish.
    wr_base = wr_cycles;
    push_exp(K_ROB, 32'd0);
    run_req(K_ROB, 32'h200, SW, 32'hDEAD_BEEF, n0);
    @(negedge clk_in);
    check("sw_wr_cycles", 32'(wr_cycles - wr_base), 32'd4);
    check("sw_ram", {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]}, 32'hDEAD_BEEF);
    @(posedge clk_in); #1;

    // All three at once: store, then load, then fetch.
    push_exp(K_ROB, 32'd0);
    push_exp(K_LB, 32'h0000_0080);
    push_exp(K_IF, 32'h0000_0513);
    fork
      run_req(K_ROB, 32'h210, SB, 32'h0000_005A, n0);
      run_req(K_LB, 32'h80, LBU, 32'd0, n1);
      run_req(K_IF, 32'h100, LW, 32'd0, n2);
    join
    check("prio_sb_ram", 32'(ram[10'h210]), 32'h5A);
    @(posedge clk_in); #1;

    // Load aborted by a flush while byte 2 is being addressed: no completion.
    lb_addr_in = 32'h100; lb_type_in = LW; lb_en_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    flush_in = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0; lb_en_in = 1'b0;
    check("flush_idle", 32'(rob_rdy_out), 32'd1);
    repeat (6) @(posedge clk_in);
    #1;

    // Flush during a store has no effect on it.
    push_exp(K_ROB, 32'd0);
    fork
      run_req(K_ROB, 32'h220, SW, 32'h1122_3344, n0);
      begin
        repeat (2) @(posedge clk_in);
        #2 flush_in = 1'b1;
        @(posedge clk_in);
        #2 flush_in = 1'b0;
      end
    join
    @(negedge clk_in);
    check("flush_sw_ram", {ram[10'h223], ram[10'h222], ram[10'h221], ram[10'h220]}, 32'h1122_3344);
    @(posedge clk_in); #1;

    // I/O store held off by a full UART buffer, blocking the load behind it.
    io_buffer_full_in = 1'b1;
    push_exp(K_ROB, 32'd0);
    push_exp(K_LB, 32'hFFFF_FF80);
    fork
      run_req(K_ROB, 32'h30000, SB, 32'h0000_0041, n0);
      run_req(K_LB, 32'h80, LB, 32'd0, n1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk_in); #1;
          check("io_hold_wr", 32'(mem_wr), 32'd0);
          check("io_hold_idle", 32'(rob_rdy_out), 32'd1);
        end
        io_buffer_full_in = 1'b0;
      end
    join
    check("io_sb_ram", 32'(ram[10'h000]), 32'h41);
    @(posedge clk_in); #1;

    // Fetch frozen for three cycles mid-access.
    push_exp(K_IF, 32'h0010_0093);
    fork
      run_req(K_IF, 32'h104, LW, 32'd0, n0);
      begin
        repeat (2) @(posedge clk_in);
        #2 rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2 rdy_in = 1'b1;
      end
    join
    check("freeze_latency", 32'(n0), 32'd8);

    repeat (5) @(posedge clk_in);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
